// File: rtl/multdiv_stall_ctrl.sv
// Stall/sequencing control for the multi-cycle multiplier/divider in DX,
// plus the load-use interlock between DX and FD.
module multdiv_stall_ctrl #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 7
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] fd_ir,
    input  logic [31:0] dx_ir,
    input  logic        md_result_rdy,
    input  logic        md_exception,
    input  logic [31:0] md_result,
    output logic        md_ctrl_mult,
    output logic        md_ctrl_div,
    output logic        stall_fd,
    output logic        stall_dx,
    output logic        nop_dx,
    output logic        nop_xm,
    output logic        md_done,
    output logic [31:0] md_result_q,
    output logic        md_ovf,
    output logic        busy
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT - 1);

    localparam logic [4:0] OpRtype = 5'b00000;
    localparam logic [4:0] OpAddi  = 5'b00101;
    localparam logic [4:0] OpLw    = 5'b01000;
    localparam logic [4:0] OpSw    = 5'b00111;
    localparam logic [4:0] OpBne   = 5'b00010;
    localparam logic [4:0] OpBlt   = 5'b00110;
    localparam logic [4:0] OpJr    = 5'b00100;
    localparam logic [4:0] OpBex   = 5'b10110;
    localparam logic [4:0] AluMul  = 5'b00110;
    localparam logic [4:0] AluDiv  = 5'b00111;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      md_result_d;
    logic             md_ovf_q, md_ovf_d;

    logic       is_md, is_mul, is_lw, load_use;
    logic [4:0] ld_rd, src_a, src_b;
    logic       use_a, use_b;
    logic       unused_ir;

    assign unused_ir = ^{dx_ir[21:7], dx_ir[1:0], fd_ir[11:0]};

    assign is_mul = (dx_ir[31:27] == OpRtype) && (dx_ir[6:2] == AluMul);
    assign is_md  = is_mul || ((dx_ir[31:27] == OpRtype) && (dx_ir[6:2] == AluDiv));
    assign is_lw  = (dx_ir[31:27] == OpLw);
    assign ld_rd  = dx_ir[26:22];

    always_comb begin
        src_a = 5'd0;
        src_b = 5'd0;
        use_a = 1'b0;
        use_b = 1'b0;
        case (fd_ir[31:27])
            OpRtype: begin
                src_a = fd_ir[21:17];
                src_b = fd_ir[16:12];
                use_a = 1'b1;
                use_b = 1'b1;
            end
            OpAddi, OpLw: begin
                src_a = fd_ir[21:17];
                use_a = 1'b1;
            end
            OpSw, OpBne, OpBlt: begin
                src_a = fd_ir[26:22];
                src_b = fd_ir[21:17];
                use_a = 1'b1;
                use_b = 1'b1;
            end
            OpJr: begin
                src_a = fd_ir[26:22];
                use_a = 1'b1;
            end
            OpBex: begin
                src_a = 5'd30;
                use_a = 1'b1;
            end
            default: ;
        endcase
    end

    // r0 never carries a real dependency, so a load to r0 is never interlocked.
    assign load_use = is_lw && (ld_rd != 5'd0) &&
                      ((use_a && (src_a == ld_rd)) || (use_b && (src_b == ld_rd)));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        md_result_d  = md_result_q;
        md_ovf_d     = md_ovf_q;
        md_ctrl_mult = 1'b0;
        md_ctrl_div  = 1'b0;
        stall_fd     = 1'b0;
        stall_dx     = 1'b0;
        nop_dx       = 1'b0;
        nop_xm       = 1'b0;
        md_done      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (is_md) begin
                    md_ctrl_mult = is_mul;
                    md_ctrl_div  = !is_mul;
                    stall_fd     = 1'b1;
                    stall_dx     = 1'b1;
                    nop_xm       = 1'b1;
                    cnt_d        = '0;
                    md_ovf_d     = 1'b0;
                    state_d      = StRun;
                end else if (load_use) begin
                    stall_fd = 1'b1;
                    nop_dx   = 1'b1;
                end
            end
            StRun: begin
                stall_fd = 1'b1;
                stall_dx = 1'b1;
                nop_xm   = 1'b1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (md_result_rdy) begin
                    md_result_d = md_result;
                    md_ovf_d    = md_exception;
                    state_d     = StDone;
                end else if (cnt_q == CntLast) begin
                    md_result_d = 32'h0;
                    md_ovf_d    = 1'b1;
                    state_d     = StDone;
                end
            end
            StDone: begin
                md_done = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // The IDLE decode is combinational, so gate it off while reset is held.
        if (!reset) begin
            md_ctrl_mult = 1'b0;
            md_ctrl_div  = 1'b0;
            stall_fd     = 1'b0;
            stall_dx     = 1'b0;
            nop_dx       = 1'b0;
            nop_xm       = 1'b0;
            md_done      = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            md_result_q <= 32'h0;
            md_ovf_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            md_result_q <= md_result_d;
            md_ovf_q    <= md_ovf_d;
        end
    end

    assign md_ovf = md_ovf_q;
    assign busy   = (state_q != StIdle);

endmodule

// File: tb/tb_multdiv_stall_ctrl.sv
// Scoreboard bench for multdiv_stall_ctrl: expected completions are queued as
// the multdiv response is driven and checked when md_done fires.
module tb_multdiv_stall_ctrl;

    logic        clk;
    logic        reset;
    logic [31:0] fd_ir, dx_ir, md_result;
    logic        md_result_rdy, md_exception;
    logic        md_ctrl_mult, md_ctrl_div, stall_fd, stall_dx, nop_dx, nop_xm;
    logic        md_done, md_ovf, busy;
    logic [31:0] md_result_q;

    typedef struct packed {
        logic [31:0] res;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    multdiv_stall_ctrl #(.TIMEOUT(64), .CNT_W(7)) dut (
        .clock        (clk),
        .reset        (reset),
        .fd_ir        (fd_ir),
        .dx_ir        (dx_ir),
        .md_result_rdy(md_result_rdy),
        .md_exception (md_exception),
        .md_result    (md_result),
        .md_ctrl_mult (md_ctrl_mult),
        .md_ctrl_div  (md_ctrl_div),
        .stall_fd     (stall_fd),
        .stall_dx     (stall_dx),
        .nop_dx       (nop_dx),
        .nop_xm       (nop_xm),
        .md_done      (md_done),
        .md_result_q  (md_result_q),
        .md_ovf       (md_ovf),
        .busy         (busy)
    );

    logic [7:0] ctl;
    assign ctl = {md_ctrl_mult, md_ctrl_div, stall_fd, stall_dx, nop_dx, nop_xm, md_done, busy};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rtype(input logic [4:0] rd, rs, rt, alu);
        return {5'b00000, rd, rs, rt, 5'b00000, alu, 2'b00};
    endfunction

    function automatic logic [31:0] itype(input logic [4:0] op, rd, rs);
        return {op, rd, rs, 17'h0};
    endfunction

    // Drives one mul/div from issue to completion; rdy_at == 0 means never ready.
    task automatic drive_md(input logic [31:0] instr, input int rdy_at, input logic [31:0] res,
                            input logic exc, input logic [31:0] next_ir,
                            output int n_mult, output int n_div, output int n_stall,
                            output int done_at);
        exp_t e;
        bit   done;
        bit   rdy;
        n_mult  = 0;
        n_div   = 0;
        n_stall = 0;
        done_at = -1;
        done    = 0;
        dx_ir   = instr;
        if (rdy_at == 0) sb.push_back('{res: 32'h0, ovf: 1'b1});
        for (int c = 0; c < 100 && !done; c++) begin
            rdy           = (rdy_at != 0) && (c == rdy_at);
            md_result_rdy = rdy;
            md_result     = rdy ? res : 32'hdead_beef;
            md_exception  = rdy ? exc : 1'b1;
            if (rdy) sb.push_back('{res: res, ovf: exc});
            @(negedge clk);
            if (md_ctrl_mult) n_mult++;
            if (md_ctrl_div) n_div++;
            if (stall_fd && stall_dx && nop_xm) n_stall++;
            if (md_done) begin
                done    = 1;
                done_at = c;
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected_done: md_done with empty scoreboard at cycle %0d", c);
                end else begin
                    e = sb.pop_front();
                    if ({md_result_q, md_ovf} !== {e.res, e.ovf}) begin
                        failures++;
                        $display("FAIL sb_result: got res=%h ovf=%b, want res=%h ovf=%b",
                                 md_result_q, md_ovf, e.res, e.ovf);
                    end
                end
            end
            @(posedge clk);
            #1;
        end
        md_result_rdy = 1'b0;
        md_exception  = 1'b0;
        dx_ir         = next_ir;
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL md_done_timeout: got no md_done, want one within 100 cycles");
        end
    endtask

    task automatic test_reset();
        dx_ir = rtype(5'd3, 5'd1, 5'd2, 5'b00110);
        @(negedge clk);
        checks++;
        if ({ctl, md_result_q, md_ovf} !== 41'h0) begin
            failures++;
            $display("FAIL reset_outputs: got ctl=%b res=%h ovf=%b, want all 0", ctl, md_result_q, md_ovf);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        dx_ir = 32'h0;
    endtask

    task automatic test_mul();
        int nm, nd, ns, da;
        drive_md(rtype(5'd3, 5'd1, 5'd2, 5'b00110), 17, 32'h0000_0030, 1'b0, 32'h0, nm, nd, ns, da);
        checks++;
        if ({nm, nd, ns, da} !== {32'd1, 32'd0, 32'd18, 32'd18}) begin
            failures++;
            $display("FAIL mul_timing: got mult=%0d div=%0d stall=%0d done_at=%0d, want 1 0 18 18",
                     nm, nd, ns, da);
        end
    endtask

    task automatic test_div_exception();
        int nm, nd, ns, da;
        drive_md(rtype(5'd4, 5'd1, 5'd2, 5'b00111), 5, 32'h0000_0007, 1'b1, 32'h0, nm, nd, ns, da);
        checks++;
        if ({nm, nd, ns, da} !== {32'd0, 32'd1, 32'd6, 32'd6}) begin
            failures++;
            $display("FAIL div_timing: got mult=%0d div=%0d stall=%0d done_at=%0d, want 0 1 6 6",
                     nm, nd, ns, da);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({md_ovf, md_result_q, ctl} !== {1'b1, 32'h7, 8'h00}) begin
                failures++;
                $display("FAIL div_ovf_hold: got ovf=%b res=%h ctl=%b, want 1 00000007 00000000",
                         md_ovf, md_result_q, ctl);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_timeout();
        int nm, nd, ns, da;
        drive_md(rtype(5'd5, 5'd6, 5'd7, 5'b00110), 0, 32'h0, 1'b0, 32'h0, nm, nd, ns, da);
        checks++;
        if ({nm, ns, da} !== {32'd1, 32'd65, 32'd65}) begin
            failures++;
            $display("FAIL timeout_timing: got mult=%0d stall=%0d done_at=%0d, want 1 65 65", nm, ns, da);
        end
        @(negedge clk);
        checks++;
        if ({busy, md_ovf, md_result_q} !== {1'b0, 1'b1, 32'h0}) begin
            failures++;
            $display("FAIL timeout_idle: got busy=%b ovf=%b res=%h, want 0 1 00000000",
                     busy, md_ovf, md_result_q);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_load_use();
        logic [31:0] lu_dx [7];
        logic [31:0] lu_fd [7];
        logic        lu_exp[7];
        lu_dx[0] = itype(5'b01000, 5'd5, 5'd1);  lu_fd[0] = rtype(5'd6, 5'd5, 5'd2, 5'd0);  lu_exp[0] = 1;
        lu_dx[1] = itype(5'b01000, 5'd0, 5'd1);  lu_fd[1] = rtype(5'd6, 5'd5, 5'd2, 5'd0);  lu_exp[1] = 0;
        lu_dx[2] = itype(5'b01000, 5'd0, 5'd1);  lu_fd[2] = rtype(5'd6, 5'd0, 5'd2, 5'd0);  lu_exp[2] = 0;
        lu_dx[3] = itype(5'b01000, 5'd5, 5'd1);  lu_fd[3] = itype(5'b00111, 5'd5, 5'd7);    lu_exp[3] = 1;
        lu_dx[4] = itype(5'b01000, 5'd5, 5'd1);  lu_fd[4] = rtype(5'd6, 5'd1, 5'd2, 5'd0);  lu_exp[4] = 0;
        lu_dx[5] = itype(5'b01000, 5'd30, 5'd1); lu_fd[5] = {5'b10110, 27'h0};              lu_exp[5] = 1;
        lu_dx[6] = itype(5'b01000, 5'd2, 5'd1);  lu_fd[6] = rtype(5'd6, 5'd5, 5'd2, 5'd0);  lu_exp[6] = 1;
        for (int i = 0; i < 7; i++) begin
            dx_ir = lu_dx[i];
            fd_ir = lu_fd[i];
            @(negedge clk);
            checks++;
            if (ctl !== (lu_exp[i] ? 8'b0010_1000 : 8'b0000_0000)) begin
                failures++;
                $display("FAIL load_use_%0d: got ctl=%b, want stall=%b", i, ctl, lu_exp[i]);
            end
            @(posedge clk);
            #1;
            dx_ir = 32'h0;
            @(negedge clk);
            checks++;
            if (ctl !== 8'h00) begin
                failures++;
                $display("FAIL load_use_release_%0d: got ctl=%b, want 00000000", i, ctl);
            end
            @(posedge clk);
            #1;
        end
        fd_ir = 32'h0;
    endtask

    task automatic test_back_to_back();
        int nm, nd, ns, da;
        logic [31:0] mul_ir;
        mul_ir = rtype(5'd8, 5'd9, 5'd10, 5'b00110);
        drive_md(mul_ir, 3, 32'h0000_0011, 1'b0, mul_ir, nm, nd, ns, da);
        checks++;
        if ({nm, ns, da} !== {32'd1, 32'd4, 32'd4}) begin
            failures++;
            $display("FAIL b2b_first: got mult=%0d stall=%0d done_at=%0d, want 1 4 4", nm, ns, da);
        end
        drive_md(mul_ir, 4, 32'h0000_0022, 1'b0, 32'h0, nm, nd, ns, da);
        checks++;
        if ({nm, ns, da} !== {32'd1, 32'd5, 32'd5}) begin
            failures++;
            $display("FAIL b2b_second: got mult=%0d stall=%0d done_at=%0d, want 1 5 5", nm, ns, da);
        end
        @(negedge clk);
        checks++;
        if (ctl !== 8'h00) begin
            failures++;
            $display("FAIL b2b_no_extra: got ctl=%b, want 00000000", ctl);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_run();
        int nm, nd, ns, da;
        dx_ir = rtype(5'd3, 5'd1, 5'd2, 5'b00110);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        checks++;
        if (ctl !== 8'b0011_0101) begin
            failures++;
            $display("FAIL run5_state: got ctl=%b, want 00110101", ctl);
        end
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if ({ctl, md_result_q, md_ovf} !== 41'h0) begin
            failures++;
            $display("FAIL async_reset: got ctl=%b res=%h ovf=%b, want all 0", ctl, md_result_q, md_ovf);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (ctl !== 8'h00) begin
            failures++;
            $display("FAIL reset_no_start: got ctl=%b, want 00000000", ctl);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        drive_md(dx_ir, 2, 32'h0000_0005, 1'b0, 32'h0, nm, nd, ns, da);
        checks++;
        if ({nm, da} !== {32'd1, 32'd3}) begin
            failures++;
            $display("FAIL reset_restart: got mult=%0d done_at=%0d, want 1 3", nm, da);
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover: got %0d pending, want 0", sb.size());
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, want finish before 100000 ns");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b0;
        fd_ir         = 32'h0;
        dx_ir         = 32'h0;
        md_result     = 32'h0;
        md_result_rdy = 1'b0;
        md_exception  = 1'b0;
        test_reset();
        test_mul();
        test_div_exception();
        test_timeout();
        test_load_use();
        test_back_to_back();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multdiv_stall_ctrl.md
Name: multdiv_stall_ctrl

Overview:
- Sequences the multi-cycle multiplier/divider in the 5-stage pipeline.
- Detects mul/div in DX, issues a one-cycle start pulse, freezes PC/FD/DX, feeds bubbles to XM until the unit reports ready (or times out), then releases the instruction into XM with a latched result and overflow flag.
- Also generates the load-use interlock, which bypassing cannot cover.

Parameters:
- TIMEOUT, 64: max RUN cycles before forcing an error completion.
- CNT_W, 7: counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- fd_ir  in  32  instruction in FD latch
- dx_ir  in  32  instruction in DX latch
- md_result_rdy  in  1  multdiv result valid (sampled only in RUN)
- md_exception  in  1  multdiv exception (overflow / divide-by-zero), qualified by md_result_rdy
- md_result  in  32  multdiv product/quotient
- md_ctrl_mult  out  1  start-multiply pulse
- md_ctrl_div  out  1  start-divide pulse
- stall_fd  out  1  hold PC and FD latch
- stall_dx  out  1  hold DX latch
- nop_dx  out  1  load 0 into DX instead of FD contents
- nop_xm  out  1  load 0 into XM instead of DX/ALU output
- md_done  out  1  DX mul/div advances this edge; XM takes md_result_q
- md_result_q  out  32  latched result
- md_ovf  out  1  latched exception; XM writes rstatus/r30
- busy  out  1  state != IDLE

Behaviour:
- Decode:
  - is_md: dx_ir[31:27]==00000 and dx_ir[6:2] in {00110 mul, 00111 div}.
  - is_lw: opcode 01000. Load destination ld_rd = dx_ir[26:22].
- FD source registers:
  - R-type: [21:17] and [16:12].
  - I-type: [21:17].
  - sw (00111), bne (00010), blt (00110): [26:22] and [21:17].
  - jr (00100): [26:22].
  - bex (10110): r30.
- States: IDLE, RUN, DONE. Counter cnt[CNT_W-1:0].
- IDLE:
  - If is_md: assert md_ctrl_mult or md_ctrl_div (Mealy, this cycle only), stall_fd=1, stall_dx=1, nop_xm=1. Clear cnt and md_ovf. Next state RUN.
  - Else if is_lw, ld_rd!=0 and ld_rd matches any FD source: stall_fd=1, nop_dx=1. One cycle only; the lw leaves DX at the edge.
  - Otherwise all control outputs are 0.
- RUN:
  - stall_fd=stall_dx=nop_xm=1; start pulses are 0; cnt increments each cycle.
  - If md_result_rdy: latch md_result into md_result_q and md_exception into md_ovf; next state DONE.
  - Else if cnt==TIMEOUT-1: md_result_q=0, md_ovf=1; next state DONE.
  - md_result_rdy has priority over timeout in the same cycle.
- DONE:
  - All stall/nop outputs 0; md_done=1 for exactly one cycle.
  - md_result_q and md_ovf are stable through this cycle.
  - Next state IDLE. In that IDLE cycle DX already holds the following instruction, so a back-to-back mul/div restarts immediately with no double issue.
- Outputs:
  - md_result_q and md_ovf hold until the next start.
  - busy=1 in RUN and DONE.
  - Load-use detection is suppressed outside IDLE.
  - md_result_rdy and md_exception are ignored in IDLE and DONE.
- Reset:
  - Asserting reset (low) at any time, including mid-RUN, forces IDLE asynchronously.
  - cnt=0, md_result_q=0, md_ovf=0; all outputs 0.
  - No start pulse is issued while reset is low.
- Instruction word 0 (nop) never stalls.

Test Plan:
1. dx_ir = mul r3,r1,r2. md_result_rdy pulses with md_result=0x0000_0030 on the 17th RUN cycle:
   - md_ctrl_mult high exactly one cycle.
   - stall_fd/stall_dx/nop_xm high for 18 cycles (issue + 17 RUN).
   - md_done for 1 cycle with md_result_q=0x30, md_ovf=0.
2. div with md_exception=1 at rdy:
   - md_ctrl_div single pulse.
   - md_done with md_ovf=1.
   - A following nop in IDLE does not clear md_ovf.
3. mul with md_result_rdy never asserted, TIMEOUT=64:
   - DONE entered after 64 RUN cycles.
   - md_result_q=0, md_ovf=1.
   - Then back to IDLE.
4. Load-use interlock:
   - dx=lw r5,0(r1), fd=add r6,r5,r2 -> stall_fd=nop_dx=1 for exactly one cycle.
   - Same pair with lw r0 -> no stall.
   - fd=sw r5,0(r7) -> stall.
5. Back-to-back mul, mul:
   - Two distinct start pulses separated by the DONE and IDLE cycles.
   - Two md_done pulses, no extra start.
6. Reset low on the 5th RUN cycle:
   - All outputs 0 immediately, state IDLE.
   - After release with dx_ir still mul, a fresh start pulse is issued.
